// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the CPU core.
// Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK,
// driving the memory handshake, IR/MDR loads, register-file write, the
// writeback mux and the PC update controls.
// Optional feature: define SEQ_MEM_TIMEOUT_EN to abort a memory access that
// waits TIMEOUT_CYCLES consecutive cycles (HALT with a sticky bus_error).
// Without the macro, memory waits are unbounded and bus_error is tied 0.

module alu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        cond_true,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        mdr_load,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STOR,
    CL_JAL,
    CL_JCOND,
    CL_BCOND
  } cls_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MDR  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // Reject timeout values the 8-bit wait counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_sequencer: TIMEOUT_CYCLES must be in 2..255");
  end

  state_t state_q, state_d;
  cls_t   cls_q, dec_cls;
  logic   taken_q;
  logic   timeout_hit;

  // Classify the opcode {instr[15:12], instr[7:4]} while the IR is stable.
  always_comb begin
    dec_cls = CL_ALU;
    if (instr[15:12] == 4'b0100) begin
      case (instr[7:4])
        4'b0000: dec_cls = CL_LOAD;
        4'b0100: dec_cls = CL_STOR;
        4'b1000: dec_cls = CL_JAL;
        4'b1100: dec_cls = CL_JCOND;
        default: dec_cls = CL_ALU;
      endcase
    end else if (instr[15:12] == 4'b1100) begin
      dec_cls = CL_BCOND;
    end
  end

  // State, instruction class and branch-taken registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cls_q   <= CL_ALU;
      taken_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of the others, independent of statement order.
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
      end
      if (state_q == S_EXECUTE) begin
        case (cls_q)
          CL_BCOND, CL_JCOND: taken_q <= cond_true;
          CL_JAL:             taken_q <= 1'b1;
          default:            taken_q <= 1'b0;
        endcase
      end
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       bus_err_q;
  logic       in_mem_phase;
  logic       mem_wait;

  assign in_mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem_wait     = in_mem_phase && !mem_ready;
  // The counter holds the number of completed wait cycles, so the
  // TIMEOUT_CYCLES-th wait cycle is the one seeing TIMEOUT_CYCLES-1.
  assign timeout_hit  = mem_wait && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign bus_error    = bus_err_q;

  // Consecutive-wait counter (zero outside memory phases) and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      if (!in_mem_phase) begin
        wait_cnt <= 8'd0;
      end else if (mem_wait) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // Next-state logic and Moore outputs (ir_load/mdr_load follow mem_ready).
  always_comb begin
    // NOTE: every output and the next state get a default first, so no
    // branch of the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        state_d = (instr == 16'h0000) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = (cls_q == CL_LOAD || cls_q == CL_STOR) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CL_STOR);
        mdr_load     = mem_ready;
        if (mem_ready) begin
          state_d = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        case (cls_q)
          CL_ALU: begin
            reg_we = 1'b1;
            wb_sel = WB_ALU;
            pc_inc = 1'b1;
          end
          CL_LOAD: begin
            reg_we = 1'b1;
            wb_sel = WB_MDR;
            pc_inc = 1'b1;
          end
          CL_STOR: begin
            pc_inc = 1'b1;
          end
          CL_BCOND: begin
            pc_load = taken_q;
            pc_inc  = !taken_q;
            pc_src  = 1'b0;
          end
          CL_JCOND: begin
            pc_load = taken_q;
            pc_inc  = !taken_q;
            pc_src  = 1'b1;
          end
          CL_JAL: begin
            reg_we  = 1'b1;
            wb_sel  = WB_LINK;
            pc_load = 1'b1;
            pc_src  = 1'b1;
          end
          default: begin
            pc_inc = 1'b1;
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: each scenario queues per-cycle
// stimulus with the expected output vector, and compares the DUT outputs
// sampled on the falling edge against the scoreboard entry.

module tb_alu_sequencer;

  logic        clock;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        cond_true;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_load;
  logic        mdr_load;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_inc;
  logic        pc_load;
  logic        pc_src;
  logic [2:0]  state;
  logic        halted;
  logic        bus_error;

  alu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .cond_true    (cond_true),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .mdr_load     (mdr_load),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_src       (pc_src),
    .state        (state),
    .halted       (halted),
    .bus_error    (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       irl;
    logic       mdl;
    logic       rwe;
    logic [1:0] wb;
    logic       inc;
    logic       ld;
    logic       src;
    logic       hlt;
    logic       berr;
  } obs_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        cond;
    logic [15:0] ins;
    obs_t        e;
  } step_t;

  obs_t  sb[$];
  obs_t  got;
  obs_t  exp_v;
  int    n_vec  = 0;
  int    n_miss = 0;

  localparam logic [15:0] I_ALU   = 16'h0521;
  localparam logic [15:0] I_LOAD  = 16'h4000;
  localparam logic [15:0] I_STOR  = 16'h4040;
  localparam logic [15:0] I_JAL   = 16'h4080;
  localparam logic [15:0] I_JCOND = 16'h40C5;
  localparam logic [15:0] I_BCOND = 16'hC123;
  localparam logic [15:0] I_HALT  = 16'h0000;

  // Expected output vectors.
  function automatic obs_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic asel, input logic irl, input logic mdl,
                              input logic rwe, input logic [1:0] wb, input logic inc,
                              input logic ld, input logic src, input logic berr);
    return {st, req, we, asel, irl, mdl, rwe, wb, inc, ld, src, (st == 3'd6), berr};
  endfunction

  function automatic obs_t e_rst();   return mk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_fw();    return mk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_fr();    return mk(3'd1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_dec();   return mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_exe();   return mk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_mw(input logic we); return mk(3'd4, 1, we, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_mr(input logic we); return mk(3'd4, 1, we, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic obs_t e_wb(input logic rwe, input logic [1:0] wb, input logic inc,
                                input logic ld, input logic src);
    return mk(3'd5, 0, 0, 0, 0, 0, rwe, wb, inc, ld, src, 0);
  endfunction
  function automatic obs_t e_halt(input logic berr); return mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, berr); endfunction

  function automatic step_t stp(input logic rst, input logic rdy, input logic cond,
                                input logic [15:0] ins, input obs_t e);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.cond = cond; s.ins = ins; s.e = e;
    return s;
  endfunction

  function automatic obs_t sample();
    return {state, mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, reg_we, wb_sel,
            pc_inc, pc_load, pc_src, halted, bus_error};
  endfunction

  // Drive one cycle of stimulus (just after the rising edge), record the
  // expectation, and move to the sampling point on the falling edge.
  task automatic apply(input step_t s);
    reset     = s.rst;
    mem_ready = s.rdy;
    cond_true = s.cond;
    instr     = s.ins;
    sb.push_back(s.e);
    @(negedge clock);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step_t seq[$];
    reset = 1'b0; mem_ready = 1'b1; cond_true = 1'b1; instr = I_ALU;
    advance();
    seq.push_back(stp(0, 1, 1, I_ALU, e_rst()));
    seq.push_back(stp(0, 1, 1, I_ALU, e_rst()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL reset[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_alu();
    step_t seq[$];
    seq.push_back(stp(1, 0, 0, I_ALU, e_rst()));
    seq.push_back(stp(1, 1, 0, I_ALU, e_fr()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_dec()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_exe()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_wb(1, 2'b00, 1, 0, 0)));
    seq.push_back(stp(1, 0, 0, I_ALU, e_fw()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL alu[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_load();
    step_t seq[$];
    seq.push_back(stp(1, 1, 0, I_LOAD, e_fr()));
    seq.push_back(stp(1, 1, 1, I_LOAD, e_dec()));
    seq.push_back(stp(1, 1, 1, I_LOAD, e_exe()));
    for (int k = 0; k < 3; k++) seq.push_back(stp(1, 0, 0, I_LOAD, e_mw(0)));
    seq.push_back(stp(1, 1, 0, I_LOAD, e_mr(0)));
    seq.push_back(stp(1, 0, 0, I_LOAD, e_wb(1, 2'b01, 1, 0, 0)));
    seq.push_back(stp(1, 0, 0, I_LOAD, e_fw()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL load[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_stor();
    step_t seq[$];
    seq.push_back(stp(1, 1, 0, I_STOR, e_fr()));
    seq.push_back(stp(1, 0, 0, I_STOR, e_dec()));
    seq.push_back(stp(1, 0, 0, I_STOR, e_exe()));
    seq.push_back(stp(1, 1, 0, I_STOR, e_mr(1)));
    seq.push_back(stp(1, 0, 0, I_STOR, e_wb(0, 2'b00, 1, 0, 0)));
    seq.push_back(stp(1, 0, 0, I_STOR, e_fw()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL stor[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

  // cond_true is set opposite to the EXECUTE value in the other cycles so
  // only the EXECUTE sample can produce the expected result.
  task automatic test_branch();
    step_t seq[$];
    logic [15:0] ins;
    logic        src;
    for (int b = 0; b < 2; b++) begin
      ins = (b == 0) ? I_BCOND : I_JCOND;
      src = (b == 0) ? 1'b0 : 1'b1;
      for (int t = 1; t >= 0; t--) begin
        seq.push_back(stp(1, 1, !t[0], ins, e_fr()));
        seq.push_back(stp(1, 0, !t[0], ins, e_dec()));
        seq.push_back(stp(1, 0, t[0],  ins, e_exe()));
        seq.push_back(stp(1, 0, !t[0], ins, e_wb(0, 2'b00, !t[0], t[0], src)));
        seq.push_back(stp(1, 0, !t[0], ins, e_fw()));
      end
    end
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL branch[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_jal();
    step_t seq[$];
    seq.push_back(stp(1, 1, 0, I_JAL, e_fr()));
    seq.push_back(stp(1, 0, 0, I_JAL, e_dec()));
    seq.push_back(stp(1, 0, 0, I_JAL, e_exe()));
    seq.push_back(stp(1, 0, 0, I_JAL, e_wb(1, 2'b10, 0, 1, 1)));
    seq.push_back(stp(1, 0, 0, I_JAL, e_fw()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL jal[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

`ifdef SEQ_MEM_TIMEOUT_EN
  task automatic test_timeout();
    step_t seq[$];
    seq.push_back(stp(0, 0, 0, I_ALU, e_rst()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_rst()));
    for (int k = 0; k < 4; k++) seq.push_back(stp(1, 0, 0, I_ALU, e_fw()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_halt(1)));
    seq.push_back(stp(1, 1, 0, I_ALU, e_halt(1)));
    seq.push_back(stp(1, 0, 0, I_ALU, e_halt(1)));
    seq.push_back(stp(0, 0, 0, I_ALU, e_rst()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_rst()));
    for (int k = 0; k < 3; k++) seq.push_back(stp(1, 0, 0, I_ALU, e_fw()));
    seq.push_back(stp(1, 1, 0, I_ALU, e_fr()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_dec()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_exe()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_wb(1, 2'b00, 1, 0, 0)));
    seq.push_back(stp(1, 0, 0, I_ALU, e_fw()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL timeout[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask
`else
  // Without the timeout feature a long FETCH wait must neither abort nor
  // raise bus_error.
  task automatic test_long_wait();
    step_t seq[$];
    for (int k = 0; k < 70; k++) seq.push_back(stp(1, 0, 0, I_ALU, e_fw()));
    seq.push_back(stp(1, 1, 0, I_ALU, e_fr()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_dec()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_exe()));
    seq.push_back(stp(1, 0, 0, I_ALU, e_wb(1, 2'b00, 1, 0, 0)));
    seq.push_back(stp(1, 0, 0, I_ALU, e_fw()));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL long_wait[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask
`endif

  task automatic test_reset_mid_halt();
    step_t seq[$];
    step_t post[$];
    seq.push_back(stp(1, 1, 0, I_LOAD, e_fr()));
    seq.push_back(stp(1, 0, 0, I_LOAD, e_dec()));
    seq.push_back(stp(1, 0, 0, I_LOAD, e_exe()));
    seq.push_back(stp(1, 0, 0, I_LOAD, e_mw(0)));
    seq.push_back(stp(1, 0, 0, I_LOAD, e_mw(0)));
    foreach (seq[i]) begin
      apply(seq[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL mid_reset_pre[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
    // Still waiting in MEM: pull reset between clock edges.
    mem_ready = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_miss++;
      $display("FAIL mid_reset_req_before: got mem_req=%b, want 1", mem_req);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0) begin
      n_miss++;
      $display("FAIL mid_reset_req_async: got mem_req=%b, want 0", mem_req);
    end
    n_vec++;
    if (state !== 3'd0) begin
      n_miss++;
      $display("FAIL mid_reset_state_async: got state=%0d, want 0", state);
    end
    advance();
    post.push_back(stp(0, 1, 0, I_HALT, e_rst()));
    post.push_back(stp(1, 0, 0, I_HALT, e_rst()));
    post.push_back(stp(1, 1, 0, I_HALT, e_fr()));
    post.push_back(stp(1, 0, 0, I_HALT, e_dec()));
    for (int k = 0; k < 4; k++) post.push_back(stp(1, k[0], 0, I_ALU, e_halt(0)));
    foreach (post[i]) begin
      apply(post[i]);
      got = sample(); exp_v = sb.pop_front(); n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL mid_reset_post[%0d]: got state=%0d vec=%h, want state=%0d vec=%h", i, got.st, got, exp_v.st, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; cond_true = 1'b0; instr = 16'h0000;
    test_reset();
    test_alu();
    test_load();
    test_stor();
    test_branch();
    test_jal();
`ifdef SEQ_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation still running at 100us, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
